counter_cmd_sequencer: RTL and testbench

//  Upstream control stage for the 16-bit loadable up/down counter (`counter`).

---
 rtl/counter_seq_pkg.sv | 23 ++
 rtl/counter_cmd_sequencer_step_ctr.sv | 36 +++
 rtl/counter_cmd_sequencer.sv | 116 +++++++++++
 tb/tb_counter_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
//   cmd_op_e : command opcodes carried on cmd_op
//   state_e  : sequencer FSM states
//   DEFAULT_WIDTH : default counter/data width
package counter_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_GOTO = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/counter_cmd_sequencer_step_ctr.sv
// Remaining-step counter for the sequencer RUN phase.
// Ports:
//   clk, rst_  : clock, synchronous active-low reset (count cleared)
//   load       : load load_val (has priority over dec)
//   load_val   : step count to load
//   dec        : decrement by one (ignored when already zero)
//   zero       : count is zero
//   last       : count is one, i.e. the next decrement finishes the run
module cnt_seq_step_ctr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer driving the control pins of a loadable up/down counter.
// Accepts LOAD/UP/DOWN/GOTO commands over valid/ready and produces the
// counter's ld_cnt/updn_cnt/count_enb/data_in cycle-exactly.
// Ports:
//   clk, rst_            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (accepted only in IDLE)
//   cmd_op, cmd_arg      : opcode and argument (value / step count / target)
//   pause                : stalls counting while in RUN
//   cnt_q                : counter data_out feedback, used by GOTO
//   data_in, ld_cnt      : load value and active-low load strobe to counter
//   updn_cnt, count_enb  : count direction (1=up) and enable to counter
//   busy, done           : not-idle flag, one-cycle completion pulse
module counter_cmd_sequencer #(
  parameter int unsigned WIDTH = counter_seq_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             pause,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done
);

  import counter_seq_pkg::*;

  state_e           state;
  state_e           state_nxt;
  cmd_op_e          op;
  logic             accept;
  logic             goto_up;
  logic [WIDTH-1:0] goto_dist;
  logic [WIDTH-1:0] run_steps;
  logic             run_up;
  logic [WIDTH-1:0] data_q;
  logic             updn_q;
  logic             steps_zero;
  logic             steps_last;

  assign op     = cmd_op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  // GOTO becomes a relative move: cnt_q is stable in IDLE, so the distance
  // computed at accept is exact.
  assign goto_up   = (cmd_arg >= cnt_q);
  assign goto_dist = goto_up ? (cmd_arg - cnt_q) : (cnt_q - cmd_arg);
  assign run_steps = (op == OP_GOTO) ? goto_dist : cmd_arg;
  assign run_up    = (op == OP_UP) || ((op == OP_GOTO) && goto_up);

  cnt_seq_step_ctr #(
    .WIDTH (WIDTH)
  ) u_step_ctr (
    .clk      (clk),
    .rst_     (rst_),
    .load     (accept && (op != OP_LOAD)),
    .load_val (run_steps),
    .dec      (count_enb),
    .zero     (steps_zero),
    .last     (steps_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_LOAD)           state_nxt = S_LOAD;
          else if (run_steps == '0)    state_nxt = S_DONE;
          else                         state_nxt = S_RUN;
        end
      end
      S_LOAD:  state_nxt = S_DONE;
      // Leave on the edge that consumes the final step so enables span
      // exactly N non-paused cycles.
      S_RUN: begin
        if (steps_zero || (count_enb && steps_last)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state  <= S_IDLE;
      data_q <= '0;
      updn_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept && (op == OP_LOAD)) begin
        data_q <= cmd_arg;
      end else if (state == S_LOAD) begin
        data_q <= '0;
      end
      if (accept && (op != OP_LOAD)) begin
        updn_q <= run_up;
      end
    end
  end

  assign data_in   = data_q;
  assign ld_cnt    = (state != S_LOAD);
  assign updn_cnt  = updn_q;
  assign count_enb = (state == S_RUN) && !pause;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign cmd_ready = rst_ && (state == S_IDLE);

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
module tb_counter_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        pause;
  logic [15:0] cnt_q;
  logic [15:0] data_in;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [15:0] ref_val = 16'h0;

  always #5 clk = ~clk;

  counter_cmd_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pause     (pause),
    .cnt_q     (cnt_q),
    .data_in   (data_in),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .busy      (busy),
    .done      (done)
  );

  // Downstream 16-bit loadable up/down counter.
  always_ff @(posedge clk) begin
    if (!rst_)          cnt_q <= 16'h0;
    else if (!ld_cnt)   cnt_q <= data_in;
    else if (count_enb) cnt_q <= updn_cnt ? cnt_q + 16'd1 : cnt_q - 16'd1;
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] arg;
    logic [31:0] pm;
    int          en;
    int          dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Done cycle from the rules: N non-paused RUN cycles, then DONE.
  function automatic int ref_done(input int n, input logic [31:0] pm);
    int k = 0;
    int c = 1;
    if (n == 0) return 1;
    while (k < n) begin
      if (!(c < 32 && pm[c])) k++;
      c++;
    end
    return c;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] arg, input logic [31:0] pm,
                         input int exp_en, input int exp_done, input logic [15:0] exp_cnt,
                         input string tag);
    int en = 0;
    int ld = 0;
    int done_at = 0;
    logic dir;
    dir = (op == 2'd1) || ((op == 2'd3) && (arg >= ref_val));
    chk({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
    cmd_arg   = 16'($urandom);
    for (int c = 1; c <= 300 && done_at == 0; c++) begin
      pause = (c < 32) ? pm[c] : 1'b0;
      #1;
      if (!ld_cnt) begin
        ld++;
        chk({tag, ".ld_data"}, 32'(data_in), 32'(arg));
      end
      if (count_enb) begin
        en++;
        chk({tag, ".updn"}, 32'(updn_cnt), 32'(dir));
      end
      chk({tag, ".ld_en_excl"}, 32'(!ld_cnt && count_enb), 32'd0);
      if (done) done_at = c;
      else step();
    end
    pause = 1'b0;
    chk({tag, ".done_cycle"}, 32'(done_at), 32'(exp_done));
    chk({tag, ".enables"}, 32'(en), 32'(exp_en));
    chk({tag, ".ld_strobes"}, 32'(ld), (op == 2'd0) ? 32'd1 : 32'd0);
    step();
    chk({tag, ".ready_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".cnt"}, 32'(cnt_q), 32'(exp_cnt));
    ref_val = exp_cnt;
  endtask

  initial begin
    tbl[0]  = '{2'd0, 16'h1234, 32'h0,        0, 2, 16'h1234};
    tbl[1]  = '{2'd1, 16'd5,    32'h0,        5, 6, 16'h1239};
    tbl[2]  = '{2'd1, 16'd0,    32'h0,        0, 1, 16'h1239};
    tbl[3]  = '{2'd0, 16'h0001, 32'hFFFFFFFF, 0, 2, 16'h0001};
    tbl[4]  = '{2'd2, 16'd3,    32'h0,        3, 4, 16'hFFFE};
    tbl[5]  = '{2'd0, 16'h0014, 32'h0,        0, 2, 16'h0014};
    tbl[6]  = '{2'd3, 16'h0010, 32'h0,        4, 5, 16'h0010};
    tbl[7]  = '{2'd3, 16'h0010, 32'h0,        0, 1, 16'h0010};
    tbl[8]  = '{2'd1, 16'd4,    32'hC,        4, 7, 16'h0014};
    tbl[9]  = '{2'd3, 16'h0018, 32'h0,        4, 5, 16'h0018};
    tbl[10] = '{2'd0, 16'hFFFF, 32'h0,        0, 2, 16'hFFFF};
    tbl[11] = '{2'd1, 16'd2,    32'h0,        2, 3, 16'h0001};

    rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 16'h0; pause = 1'b0;
    step();
    step();
    chk("rst.data_in", 32'(data_in), 32'd0);
    chk("rst.ld_cnt", 32'(ld_cnt), 32'd1);
    chk("rst.updn", 32'(updn_cnt), 32'd1);
    chk("rst.enb", 32'(count_enb), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ready_low", 32'(cmd_ready), 32'd0);
    rst_ = 1'b1;
    #1;
    chk("rst.ready_high", 32'(cmd_ready), 32'd1);
    ref_val = 16'h0;

    for (int i = 0; i < 12; i++) begin
      run_cmd(tbl[i].op, tbl[i].arg, tbl[i].pm, tbl[i].en, tbl[i].dn, tbl[i].cnt,
              $sformatf("tbl%0d", i));
    end

    // Command held valid across a RUN is back-pressured until IDLE.
    begin
      int en = 0;
      int ld = 0;
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 16'd6;
      step();
      cmd_op = 2'd0; cmd_arg = 16'hAAAA;
      for (int c = 1; c <= 7; c++) begin
        chk("held.ready_low", 32'(cmd_ready), 32'd0);
        if (!ld_cnt) ld++;
        if (count_enb) en++;
        step();
      end
      chk("held.enables", 32'(en), 32'd6);
      chk("held.no_load", 32'(ld), 32'd0);
      chk("held.ready_idle", 32'(cmd_ready), 32'd1);
      chk("held.cnt_up", 32'(cnt_q), 32'(ref_val + 16'd6));
      step();
      cmd_valid = 1'b0;
      chk("held.ld_strobe", 32'(ld_cnt), 32'd0);
      chk("held.ld_data", 32'(data_in), 32'hAAAA);
      step();
      step();
      chk("held.cnt_loaded", 32'(cnt_q), 32'hAAAA);
      ref_val = 16'hAAAA;
    end

    // Reset in the middle of RUN aborts at that edge.
    begin
      int act = 0;
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 16'd10;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      rst_ = 1'b0;
      #1;
      chk("midrst.ready_low", 32'(cmd_ready), 32'd0);
      step();
      chk("midrst.ld_cnt", 32'(ld_cnt), 32'd1);
      chk("midrst.enb", 32'(count_enb), 32'd0);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.done", 32'(done), 32'd0);
      chk("midrst.updn", 32'(updn_cnt), 32'd1);
      chk("midrst.data_in", 32'(data_in), 32'd0);
      rst_ = 1'b1;
      #1;
      chk("midrst.ready_high", 32'(cmd_ready), 32'd1);
      for (int c = 0; c < 5; c++) begin
        if (!ld_cnt || count_enb || busy) act++;
        step();
      end
      chk("midrst.quiet", 32'(act), 32'd0);
      chk("midrst.cnt", 32'(cnt_q), 32'd0);
      ref_val = 16'h0;
    end

    // Random commands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [15:0] arg;
      logic [31:0] pm;
      int n;
      logic [15:0] exp_cnt;
      op = 2'($urandom_range(0, 3));
      pm = $urandom & $urandom & $urandom;
      case (op)
        2'd0: begin
          arg = 16'($urandom);
          n = 0;
          exp_cnt = arg;
        end
        2'd1: begin
          n = $urandom_range(0, 12);
          arg = 16'(n);
          exp_cnt = ref_val + 16'(n);
        end
        2'd2: begin
          n = $urandom_range(0, 12);
          arg = 16'(n);
          exp_cnt = ref_val - 16'(n);
        end
        default: begin
          int cur;
          int tgt;
          int d;
          cur = int'(ref_val);
          d = int'($urandom_range(0, 24)) - 12;
          tgt = cur + d;
          if (tgt < 0 || tgt > 65535) tgt = cur - d;
          n = (tgt >= cur) ? tgt - cur : cur - tgt;
          arg = 16'(tgt);
          exp_cnt = arg;
        end
      endcase
      run_cmd(op, arg, pm, n, (op == 2'd0) ? 2 : ref_done(n, pm), exp_cnt,
              $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
